uart_ld_master: RTL and testbench

- Host-side initiator for the UART memory-loader protocol; drives the byte stream that the on-chip RAM loader responds to.
- Accepts one command at a time:
  - WRITE: an address, a length and a byte stream, sent out over the UART.
  - READ: returns the responder's read-back bytes on a stream port.
  - RUN and HALT: control CPU reset.
- Sits between a command source (bench driver, or second-FPGA programmer logic) and uart_tx/uart_rx instances on the same clock.

---
 rtl/uart_ld_master.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_ld_master.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ld_master.sv
// Host-side initiator for the UART memory-loader protocol: serialises one
// WRITE/READ/RUN/HALT command onto uart_tx and collects the responder's reply.
module uart_ld_master #(
    parameter int unsigned XLEN    = 32,
    parameter logic [31:0] TIMEOUT = 32'd1000000
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    // Every stream below transfers on a cycle where vld && rdy; a vld, once
    // raised, holds until its transfer and is never derived from the matching rdy.
    input  logic [1:0]      cmd_op_i,
    input  logic [XLEN-1:0] cmd_addr_i,
    input  logic [XLEN-1:0] cmd_len_i,
    input  logic            cmd_vld_i,
    output logic            cmd_rdy_o,
    input  logic [7:0]      wr_data_i,
    input  logic            wr_data_vld_i,
    output logic            wr_data_rdy_o,
    output logic [7:0]      rd_data_o,
    output logic            rd_data_vld_o,
    input  logic            rd_data_rdy_i,
    output logic [7:0]      uart_tx_data_o,
    output logic            uart_tx_data_vld_o,
    input  logic            uart_tx_data_rdy_i,
    input  logic [7:0]      uart_rx_data_i,
    input  logic            uart_rx_data_vld_i,
    output logic            uart_rx_data_rdy_o,
    output logic            done_o,
    output logic            err_o
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;

    localparam logic [7:0] BYTE_WRITE = 8'h57;
    localparam logic [7:0] BYTE_READ  = 8'h52;
    localparam logic [7:0] BYTE_RUN   = 8'h47;
    localparam logic [7:0] BYTE_HALT  = 8'h48;
    localparam logic [7:0] BYTE_ACK   = 8'h4B;

    localparam logic [XLEN-1:0] LEN_ONE  = XLEN'(1);
    localparam logic [XLEN-1:0] LEN_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WDATA,
        S_RDATA,
        S_ACK,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q;
    logic            live_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] len_q;
    logic [XLEN-1:0] rem_q;
    logic [3:0]      idx_q;
    logic [31:0]     tmo_q;

    logic [7:0]      hdr_byte;
    logic [3:0]      hdr_last;
    logic            tx_xfer;
    logic            rx_xfer;
    logic            tmo_hit;
    logic [31:0]     tmo_inc;

    function automatic logic [7:0] op_byte(input logic [1:0] op);
        case (op)
            OP_WRITE: op_byte = BYTE_WRITE;
            OP_READ:  op_byte = BYTE_READ;
            OP_RUN:   op_byte = BYTE_RUN;
            default:  op_byte = BYTE_HALT;
        endcase
    endfunction

    // Header layout: opcode, then addr and len each least-significant byte first.
    always_comb begin
        hdr_byte = op_byte(op_q);
        case (idx_q)
            4'd1:    hdr_byte = addr_q[7:0];
            4'd2:    hdr_byte = addr_q[15:8];
            4'd3:    hdr_byte = addr_q[23:16];
            4'd4:    hdr_byte = addr_q[31:24];
            4'd5:    hdr_byte = len_q[7:0];
            4'd6:    hdr_byte = len_q[15:8];
            4'd7:    hdr_byte = len_q[23:16];
            4'd8:    hdr_byte = len_q[31:24];
            default: hdr_byte = op_byte(op_q);
        endcase
    end

    assign hdr_last = (op_q == OP_WRITE || op_q == OP_READ) ? 4'd8 : 4'd0;

    // Stream steering; live_q keeps the stray-byte drain low while in reset.
    always_comb begin
        uart_tx_data_o     = 8'h00;
        uart_tx_data_vld_o = 1'b0;
        wr_data_rdy_o      = 1'b0;
        rd_data_o          = 8'h00;
        rd_data_vld_o      = 1'b0;
        uart_rx_data_rdy_o = live_q;
        case (state_q)
            S_HDR: begin
                uart_tx_data_o     = hdr_byte;
                uart_tx_data_vld_o = 1'b1;
            end
            S_WDATA: begin
                uart_tx_data_o     = wr_data_i;
                uart_tx_data_vld_o = wr_data_vld_i;
                wr_data_rdy_o      = uart_tx_data_rdy_i;
            end
            S_RDATA: begin
                rd_data_o          = uart_rx_data_i;
                rd_data_vld_o      = uart_rx_data_vld_i;
                uart_rx_data_rdy_o = rd_data_rdy_i;
            end
            S_ACK: begin
                uart_rx_data_rdy_o = 1'b1;
            end
            default: begin
                uart_rx_data_rdy_o = live_q;
            end
        endcase
    end

    assign cmd_rdy_o = live_q && (state_q == S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign err_o     = (state_q == S_ERR);

    assign tx_xfer = uart_tx_data_vld_o && uart_tx_data_rdy_i;
    assign rx_xfer = uart_rx_data_vld_i && uart_rx_data_rdy_o;

    // Silence counter saturates; the limit is compared one step ahead so ERR
    // is entered on the edge where the count would reach TIMEOUT.
    assign tmo_inc = (tmo_q == 32'hFFFF_FFFF) ? tmo_q : tmo_q + 32'd1;
    assign tmo_hit = ({1'b0, tmo_q} + 33'd1) >= {1'b0, TIMEOUT};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            live_q  <= 1'b0;
            op_q    <= OP_WRITE;
            addr_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            idx_q   <= 4'd0;
            tmo_q   <= 32'd0;
        end else begin
            live_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (cmd_vld_i && cmd_rdy_o) begin
                        op_q    <= cmd_op_i;
                        addr_q  <= cmd_addr_i;
                        len_q   <= cmd_len_i;
                        rem_q   <= cmd_len_i;
                        idx_q   <= 4'd0;
                        tmo_q   <= 32'd0;
                        state_q <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (tx_xfer) begin
                        idx_q <= idx_q + 4'd1;
                        if (idx_q == hdr_last) begin
                            idx_q <= 4'd0;
                            tmo_q <= 32'd0;
                            case (op_q)
                                OP_WRITE: state_q <= (len_q == LEN_ZERO) ? S_ACK : S_WDATA;
                                OP_READ:  state_q <= (len_q == LEN_ZERO) ? S_DONE : S_RDATA;
                                default:  state_q <= S_ACK;
                            endcase
                        end
                    end
                end
                S_WDATA: begin
                    if (tx_xfer) begin
                        rem_q <= rem_q - LEN_ONE;
                        if (rem_q == LEN_ONE) begin
                            tmo_q   <= 32'd0;
                            state_q <= S_ACK;
                        end
                    end
                end
                S_RDATA: begin
                    if (rx_xfer) begin
                        rem_q <= rem_q - LEN_ONE;
                        tmo_q <= 32'd0;
                        if (rem_q == LEN_ONE) begin
                            state_q <= S_DONE;
                        end
                    end else if (!uart_rx_data_vld_i) begin
                        // A byte waiting on consumer back-pressure is not silence.
                        if (tmo_hit) begin
                            state_q <= S_ERR;
                        end else begin
                            tmo_q <= tmo_inc;
                        end
                    end
                end
                S_ACK: begin
                    if (uart_rx_data_vld_i) begin
                        state_q <= (uart_rx_data_i == BYTE_ACK) ? S_DONE : S_ERR;
                    end else if (tmo_hit) begin
                        state_q <= S_ERR;
                    end else begin
                        tmo_q <= tmo_inc;
                    end
                end
                S_DONE: state_q <= S_IDLE;
                S_ERR:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_ld_master.sv
// Directed bench for uart_ld_master: a byte-level protocol model predicts the
// tx stream, accepted payload, forwarded read data and done/err outcome.
module tb_uart_ld_master;

    localparam logic [31:0] TMO = 32'd100;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic [1:0]  cmd_op_i;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_len_i;
    logic        cmd_vld_i;
    logic        cmd_rdy_o;
    logic [7:0]  wr_data_i;
    logic        wr_data_vld_i;
    logic        wr_data_rdy_o;
    logic [7:0]  rd_data_o;
    logic        rd_data_vld_o;
    logic        rd_data_rdy_i;
    logic [7:0]  uart_tx_data_o;
    logic        uart_tx_data_vld_o;
    logic        uart_tx_data_rdy_i;
    logic [7:0]  uart_rx_data_i;
    logic        uart_rx_data_vld_i;
    logic        uart_rx_data_rdy_o;
    logic        done_o;
    logic        err_o;

    always #5 clk = ~clk;

    uart_ld_master #(.XLEN(32), .TIMEOUT(TMO)) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n_i),
        .cmd_op_i           (cmd_op_i),
        .cmd_addr_i         (cmd_addr_i),
        .cmd_len_i          (cmd_len_i),
        .cmd_vld_i          (cmd_vld_i),
        .cmd_rdy_o          (cmd_rdy_o),
        .wr_data_i          (wr_data_i),
        .wr_data_vld_i      (wr_data_vld_i),
        .wr_data_rdy_o      (wr_data_rdy_o),
        .rd_data_o          (rd_data_o),
        .rd_data_vld_o      (rd_data_vld_o),
        .rd_data_rdy_i      (rd_data_rdy_i),
        .uart_tx_data_o     (uart_tx_data_o),
        .uart_tx_data_vld_o (uart_tx_data_vld_o),
        .uart_tx_data_rdy_i (uart_tx_data_rdy_i),
        .uart_rx_data_i     (uart_rx_data_i),
        .uart_rx_data_vld_i (uart_rx_data_vld_i),
        .uart_rx_data_rdy_o (uart_rx_data_rdy_o),
        .done_o             (done_o),
        .err_o              (err_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_tx_edge = 0;
    int evt_cyc = 0;
    int wr_seen = 0;
    logic tx_pat = 1'b0;
    logic rd_toggle = 1'b0;

    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_wr_q[$];
    logic [7:0] exp_rd_q[$];
    logic [1:0] exp_evt_q[$];
    logic [7:0] tx_log[$];
    logic [7:0] rd_log[$];
    logic [7:0] wr_q[$];
    logic [7:0] pay_q[$];
    logic [7:0] rsp_q[$];
    logic [7:0] lit[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void check_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    function automatic logic [31:0] out_vec();
        return 32'({cmd_rdy_o, wr_data_rdy_o, rd_data_vld_o, uart_tx_data_vld_o,
                    uart_rx_data_rdy_o, done_o, err_o, rd_data_o, uart_tx_data_o});
    endfunction

    // Protocol model: what the wire, payload port, read port and outcome must show.
    function automatic void model_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] len);
        logic [7:0] opc;
        case (op)
            2'd0:    opc = 8'h57;
            2'd1:    opc = 8'h52;
            2'd2:    opc = 8'h47;
            default: opc = 8'h48;
        endcase
        exp_tx_q.push_back(opc);
        if (op[1] == 1'b0) begin
            for (int i = 0; i < 4; i++) exp_tx_q.push_back(8'(addr >> (8 * i)));
            for (int i = 0; i < 4; i++) exp_tx_q.push_back(8'(len >> (8 * i)));
        end
        if (op == 2'd0) begin
            foreach (pay_q[i]) begin
                exp_tx_q.push_back(pay_q[i]);
                exp_wr_q.push_back(pay_q[i]);
            end
        end
        if (op == 2'd1) begin
            foreach (rsp_q[i]) if (32'(i) < len) exp_rd_q.push_back(rsp_q[i]);
            exp_evt_q.push_back((32'(rsp_q.size()) >= len) ? 2'b10 : 2'b01);
        end else begin
            exp_evt_q.push_back((rsp_q.size() > 0 && rsp_q[0] == 8'h4B) ? 2'b10 : 2'b01);
        end
    endfunction

    // Sink-side ready patterns.
    initial begin
        uart_tx_data_rdy_i = 1'b0;
        rd_data_rdy_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            uart_tx_data_rdy_i = tx_pat ? (cyc % 3 != 0) : 1'b1;
            rd_data_rdy_i = rd_toggle ? ~rd_data_rdy_i : 1'b1;
        end
    end

    // Payload driver: presents wr_q in order, holding each byte until accepted.
    initial begin
        logic xfer;
        wr_data_i = 8'h00;
        wr_data_vld_i = 1'b0;
        forever begin
            @(negedge clk);
            xfer = wr_data_vld_i && wr_data_rdy_o;
            @(posedge clk); #1;
            if (xfer && wr_q.size() > 0) void'(wr_q.pop_front());
            if (wr_q.size() > 0) begin
                wr_data_i = wr_q[0];
                wr_data_vld_i = 1'b1;
            end else begin
                wr_data_i = 8'h00;
                wr_data_vld_i = 1'b0;
            end
        end
    end

    // Compare process.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_tx = 8'h00;
    always @(negedge clk) begin
        if (!rst_n_i) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) check("tx_vld_hold", 32'({uart_tx_data_vld_o, uart_tx_data_o}), 32'({1'b1, prev_tx}));
            prev_stall <= uart_tx_data_vld_o && !uart_tx_data_rdy_i;
            prev_tx <= uart_tx_data_o;
            if (uart_tx_data_vld_o && uart_tx_data_rdy_i) begin
                tx_log.push_back(uart_tx_data_o);
                if (exp_tx_q.size() == 0) check_fail("tx_unexpected_byte");
                else begin
                    check("tx_byte", 32'(uart_tx_data_o), 32'(exp_tx_q.pop_front()));
                    if (exp_tx_q.size() == 0) last_tx_edge <= cyc + 1;
                end
            end
            if (wr_data_vld_i && wr_data_rdy_o) begin
                wr_seen <= wr_seen + 1;
                if (exp_wr_q.size() == 0) check_fail("wr_unexpected_accept");
                else check("wr_accept", 32'(wr_data_i), 32'(exp_wr_q.pop_front()));
            end
            if (rd_data_vld_o && rd_data_rdy_i) begin
                rd_log.push_back(rd_data_o);
                if (exp_rd_q.size() == 0) check_fail("rd_unexpected_byte");
                else check("rd_byte", 32'(rd_data_o), 32'(exp_rd_q.pop_front()));
            end
            if (done_o || err_o) begin
                evt_cyc <= cyc;
                if (exp_evt_q.size() == 0) check_fail("unexpected_done_err");
                else check("done_err", 32'({done_o, err_o}), 32'(exp_evt_q.pop_front()));
            end
        end
    end

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] len);
        logic acc;
        cmd_op_i = op;
        cmd_addr_i = addr;
        cmd_len_i = len;
        cmd_vld_i = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = cmd_rdy_o;
            @(posedge clk); #1;
        end
        if (!acc) check_fail("cmd_not_accepted");
        cmd_vld_i = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, output logic ok);
        uart_rx_data_i = b;
        uart_rx_data_vld_i = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            ok = uart_rx_data_rdy_o;
            @(posedge clk); #1;
        end
        if (!ok) check_fail("rx_byte_stuck");
        uart_rx_data_vld_i = 1'b0;
        uart_rx_data_i = 8'h00;
    endtask

    task automatic wait_tx_drain();
        int n;
        for (n = 0; n < 3000 && exp_tx_q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        if (exp_tx_q.size() != 0) check_fail("tx_drain_timeout");
    endtask

    task automatic wait_evt();
        int n;
        for (n = 0; n < 3000 && exp_evt_q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        if (exp_evt_q.size() != 0) check_fail("done_err_timeout");
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] len);
        logic ok;
        tx_log.delete();
        rd_log.delete();
        model_cmd(op, addr, len);
        foreach (pay_q[i]) wr_q.push_back(pay_q[i]);
        send_cmd(op, addr, len);
        wait_tx_drain();
        foreach (rsp_q[i]) send_rx(rsp_q[i], ok);
        wait_evt();
        check("cmd_rdy_after_cmd", 32'(cmd_rdy_o), 32'd1);
        check("model_queues_empty", 32'(exp_tx_q.size() + exp_wr_q.size() + exp_rd_q.size()), 32'd0);
    endtask

    task automatic check_tx_log(input string name);
        check({name, "_count"}, 32'(tx_log.size()), 32'(lit.size()));
        foreach (lit[i]) check(name, (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hFFFF_FFFF, 32'(lit[i]));
    endtask

    initial begin
        logic ok;
        rst_n_i = 1'b0;
        cmd_op_i = 2'd0;
        cmd_addr_i = 32'd0;
        cmd_len_i = 32'd0;
        cmd_vld_i = 1'b0;
        uart_rx_data_i = 8'h00;
        uart_rx_data_vld_i = 1'b0;
        #1;
        check("reset_outputs", out_vec(), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n_i = 1'b1;
        @(posedge clk); #1;
        check("cmd_rdy_after_reset", 32'(cmd_rdy_o), 32'd1);

        // Stray byte in IDLE is drained.
        send_rx(8'h99, ok);
        check("stray_rx_drained", 32'(ok), 32'd1);

        // WRITE 4 bytes.
        pay_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        rsp_q = '{8'h4B};
        run_cmd(2'd0, 32'h0000_0100, 32'd4);
        lit = '{8'h57, 8'h00, 8'h01, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00,
                8'h11, 8'h22, 8'h33, 8'h44};
        check_tx_log("write_wire");

        // READ 3 bytes with consumer back-pressure.
        pay_q.delete();
        rsp_q = '{8'hAA, 8'hBB, 8'hCC};
        rd_toggle = 1'b1;
        run_cmd(2'd1, 32'h0000_0010, 32'd3);
        rd_toggle = 1'b0;
        lit = '{8'h52, 8'h10, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
        check_tx_log("read_hdr");
        check("read_data_count", 32'(rd_log.size()), 32'd3);
        if (rd_log.size() == 3) check("read_data_bytes", 32'({rd_log[0], rd_log[1], rd_log[2]}), 32'h00AABBCC);

        // RUN acked, RUN nacked, HALT acked under tx stalls.
        rsp_q = '{8'h4B};
        run_cmd(2'd2, 32'h0, 32'h0);
        lit = '{8'h47};
        check_tx_log("run_wire");
        rsp_q = '{8'h4E};
        run_cmd(2'd2, 32'h0, 32'h0);
        tx_pat = 1'b1;
        rsp_q = '{8'h4B};
        run_cmd(2'd3, 32'h0, 32'h0);
        lit = '{8'h48};
        check_tx_log("halt_wire");

        // WRITE with tx stalls across header and payload.
        pay_q = '{8'hA5, 8'h5A};
        run_cmd(2'd0, 32'hDEAD_BEEF, 32'd2);
        lit = '{8'h57, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h02, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h5A};
        check_tx_log("stall_write_wire");
        tx_pat = 1'b0;

        // READ with no response: error after TIMEOUT silent cycles.
        pay_q.delete();
        rsp_q.delete();
        run_cmd(2'd1, 32'h0000_0020, 32'd1);
        check("timeout_latency", 32'(evt_cyc - last_tx_edge), TMO);

        // WRITE len=0: payload offered but never taken.
        wr_q.push_back(8'hEE);
        rsp_q = '{8'h4B};
        run_cmd(2'd0, 32'h0000_0300, 32'd0);
        wr_q.delete();
        check("write_len0_wire_count", 32'(tx_log.size()), 32'd9);

        // Reset in the middle of a WRITE payload.
        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        rsp_q.delete();
        model_cmd(2'd0, 32'h0000_0400, 32'd4);
        foreach (pay_q[i]) wr_q.push_back(pay_q[i]);
        wr_seen = 0;
        send_cmd(2'd0, 32'h0000_0400, 32'd4);
        for (int n = 0; n < 500 && wr_seen < 2; n++) begin
            @(posedge clk); #1;
        end
        check("reset_test_two_bytes_taken", 32'(wr_seen), 32'd2);
        rst_n_i = 1'b0;
        #1;
        check("mid_reset_outputs", out_vec(), 32'd0);
        exp_tx_q.delete();
        exp_wr_q.delete();
        exp_evt_q.delete();
        wr_q.delete();
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            check("mid_reset_no_done_err", 32'({done_o, err_o}), 32'd0);
        end
        rst_n_i = 1'b1;
        @(posedge clk); #1;
        check("cmd_rdy_after_mid_reset", 32'(cmd_rdy_o), 32'd1);
        pay_q.delete();
        rsp_q = '{8'h4B};
        run_cmd(2'd2, 32'h0, 32'h0);
        check("post_reset_first_byte", (tx_log.size() > 0) ? 32'(tx_log[0]) : 32'hFFFF_FFFF, 32'h47);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
